// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline constants and the IF->DE skid-buffer state encoding.
package rv32i_pkg;

    localparam int unsigned     DEF_XLEN      = 32;
    localparam int unsigned     DEF_ILEN      = 32;
    localparam logic [31:0]     DEF_RST_PC    = 32'h0000_0000;
    localparam logic [31:0]     DEF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage : rv32i_pkg

// File: rtl/pipe_payload_reg.sv
// Width-parametrised enable-load register with an asynchronous reset value.
module pipe_payload_reg #(
    parameter int unsigned   W       = 32,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load on enable only, otherwise hold so the payload never toggles needlessly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : pipe_payload_reg

// File: rtl/if_de_skid_reg.sv
// IF->DE pipeline register with valid/ready on both sides and a 2-entry skid
// buffer so that o_Ready is a pure flop. Optional perf counters are enabled by
// defining IF_DE_SKID_REG_PERF_EN (adds o_StallCnt / o_FlushCnt ports).
module if_de_skid_reg
    import rv32i_pkg::*;
#(
    parameter int unsigned      XLEN      = DEF_XLEN,
    parameter int unsigned      ILEN      = DEF_ILEN,
    parameter logic [XLEN-1:0]  RST_PC    = DEF_RST_PC,
    parameter logic [ILEN-1:0]  NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_Flush,
    input  logic            i_Valid,
    output logic            o_Ready,
    input  logic [XLEN-1:0] i_PC,
    input  logic [XLEN-1:0] i_PCPlus4,
    input  logic [ILEN-1:0] i_Instr,
    output logic            o_Valid,
    input  logic            i_Ready,
    output logic [XLEN-1:0] o_PC,
    output logic [XLEN-1:0] o_PCPlus4,
    output logic [ILEN-1:0] o_Instr
`ifdef IF_DE_SKID_REG_PERF_EN
    ,
    output logic [31:0]     o_StallCnt,
    output logic [31:0]     o_FlushCnt
`endif
);

    localparam int unsigned     PW          = 2 * XLEN + ILEN;
    localparam logic [XLEN-1:0] RST_PC4     = RST_PC + XLEN'(4);
    localparam logic [PW-1:0]   RST_PAYLOAD = {RST_PC, RST_PC4, NOP_INSTR};

    skid_state_e     state_q;
    skid_state_e     state_d;
    logic            ready_q;
    logic            accept;
    logic            deliver;

    logic [PW-1:0]   in_payload;
    logic [PW-1:0]   main_d;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;
    logic            main_en;
    logic            skid_en;

    assign in_payload = {i_PC, i_PCPlus4, i_Instr};

    assign o_Ready   = ready_q;
    assign o_Valid   = (state_q != EMPTY);
    assign accept    = i_Valid & ready_q;
    assign deliver   = o_Valid & i_Ready;

    assign o_PC      = main_q[PW-1 -: XLEN];
    assign o_PCPlus4 = main_q[ILEN +: XLEN];
    assign o_Instr   = main_q[ILEN-1:0];

    // Main entry drives the outputs directly.
    pipe_payload_reg #(
        .W       (PW),
        .RST_VAL (RST_PAYLOAD)
    ) u_main (
        .clk  (clk),
        .rstn (rstn),
        .en   (main_en),
        .d    (main_d),
        .q    (main_q)
    );

    // Skid entry catches the one overflow accepted while DE is stalled.
    pipe_payload_reg #(
        .W       (PW),
        .RST_VAL (RST_PAYLOAD)
    ) u_skid (
        .clk  (clk),
        .rstn (rstn),
        .en   (skid_en),
        .d    (in_payload),
        .q    (skid_q)
    );

    // Next-state and payload load decisions; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_payload;
        if (i_Flush) begin
            // Keep PC/PC+4 visible, only the instruction is squashed to a NOP.
            state_d = EMPTY;
            main_en = 1'b1;
            main_d  = {main_q[PW-1:ILEN], NOP_INSTR};
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_en = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_en = 1'b1;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_en = 1'b1;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        state_d = ONE;
                        main_en = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and registered ready, the latter derived from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != TWO);
        end
    end

`ifdef IF_DE_SKID_REG_PERF_EN
    // Saturating stall/flush counters; unaffected by flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_StallCnt <= '0;
            o_FlushCnt <= '0;
        end else begin
            if (o_Valid && !i_Ready && (o_StallCnt != '1)) begin
                o_StallCnt <= o_StallCnt + 32'd1;
            end
            if (i_Flush && (o_FlushCnt != '1)) begin
                o_FlushCnt <= o_FlushCnt + 32'd1;
            end
        end
    end
`endif

endmodule : if_de_skid_reg

// File: tb/tb_if_de_skid_reg.sv
// Directed self-checking bench for if_de_skid_reg.
module tb_if_de_skid_reg;

    logic        clk;
    logic        rstn;
    logic        i_Flush;
    logic        i_Valid;
    logic        o_Ready;
    logic [31:0] i_PC;
    logic [31:0] i_PCPlus4;
    logic [31:0] i_Instr;
    logic        o_Valid;
    logic        i_Ready;
    logic [31:0] o_PC;
    logic [31:0] o_PCPlus4;
    logic [31:0] o_Instr;
`ifdef IF_DE_SKID_REG_PERF_EN
    logic [31:0] o_StallCnt;
    logic [31:0] o_FlushCnt;
`endif

    int errors = 0;
    int checks = 0;

    if_de_skid_reg dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_Flush   (i_Flush),
        .i_Valid   (i_Valid),
        .o_Ready   (o_Ready),
        .i_PC      (i_PC),
        .i_PCPlus4 (i_PCPlus4),
        .i_Instr   (i_Instr),
        .o_Valid   (o_Valid),
        .i_Ready   (i_Ready),
        .o_PC      (o_PC),
        .o_PCPlus4 (o_PCPlus4),
        .o_Instr   (o_Instr)
`ifdef IF_DE_SKID_REG_PERF_EN
        ,
        .o_StallCnt(o_StallCnt),
        .o_FlushCnt(o_FlushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        i_Valid   = v;
        i_PC      = pc;
        i_PCPlus4 = pc + 32'd4;
        i_Instr   = 32'hA000_0000 | pc;
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        i_Flush = 1'b0;
        i_Ready = 1'b0;
        drive(1'b0, 32'h0);
        repeat (3) step();
        rstn = 1'b1;
        step();
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", o_Valid); end
        checks++; if (o_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", o_Ready); end
        checks++; if (o_PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 00000000", o_PC); end
        checks++; if (o_PCPlus4 !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h exp 00000004", o_PCPlus4); end
        checks++; if (o_Instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h exp 00000013", o_Instr); end
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [3];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        i_Ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, pcs[k]);
            step();
            checks++; if (o_Valid !== 1'b1 || o_PC !== pcs[k]) begin errors++; $display("FAIL stream_pc%0d: got v=%b pc=%h exp v=1 pc=%h", k, o_Valid, o_PC, pcs[k]); end
            checks++; if (o_Instr !== (32'hA000_0000 | pcs[k]) || o_PCPlus4 !== pcs[k] + 32'd4) begin errors++; $display("FAIL stream_payload%0d: got instr=%h pc4=%h exp instr=%h pc4=%h", k, o_Instr, o_PCPlus4, 32'hA000_0000 | pcs[k], pcs[k] + 32'd4); end
            checks++; if (o_Ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b exp 1", k, o_Ready); end
        end
        drive(1'b0, 32'h0);
        step();
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b exp 0", o_Valid); end
    endtask

    task automatic test_backpressure();
        i_Ready = 1'b0;
        drive(1'b1, 32'h10);
        step();
        checks++; if (o_Valid !== 1'b1 || o_PC !== 32'h10 || o_Ready !== 1'b1) begin errors++; $display("FAIL bp_one: got v=%b pc=%h rdy=%b exp v=1 pc=00000010 rdy=1", o_Valid, o_PC, o_Ready); end
        drive(1'b1, 32'h14);
        step();
        checks++; if (o_Valid !== 1'b1 || o_PC !== 32'h10 || o_Ready !== 1'b0) begin errors++; $display("FAIL bp_two: got v=%b pc=%h rdy=%b exp v=1 pc=00000010 rdy=0", o_Valid, o_PC, o_Ready); end
        drive(1'b0, 32'h0);
        step();
        checks++; if (o_PC !== 32'h10 || o_Ready !== 1'b0 || o_Instr !== 32'hA000_0010) begin errors++; $display("FAIL bp_hold: got pc=%h rdy=%b instr=%h exp pc=00000010 rdy=0 instr=a0000010", o_PC, o_Ready, o_Instr); end
        i_Ready = 1'b1;
        step();
        checks++; if (o_Valid !== 1'b1 || o_PC !== 32'h14 || o_PCPlus4 !== 32'h18 || o_Ready !== 1'b1) begin errors++; $display("FAIL bp_shift: got v=%b pc=%h pc4=%h rdy=%b exp v=1 pc=00000014 pc4=00000018 rdy=1", o_Valid, o_PC, o_PCPlus4, o_Ready); end
        checks++; if (o_Instr !== 32'hA000_0014) begin errors++; $display("FAIL bp_shift_instr: got %h exp a0000014", o_Instr); end
        step();
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b exp 0", o_Valid); end
    endtask

    task automatic test_flush();
        // Flush while full with an input offered.
        i_Ready = 1'b0;
        drive(1'b1, 32'h20); step();
        drive(1'b1, 32'h24); step();
        checks++; if (o_Ready !== 1'b0) begin errors++; $display("FAIL flush_pre_two: got rdy=%b exp 0", o_Ready); end
        drive(1'b1, 32'h18);
        i_Flush = 1'b1;
        step();
        i_Flush = 1'b0;
        drive(1'b0, 32'h0);
        checks++; if (o_Valid !== 1'b0 || o_Ready !== 1'b1) begin errors++; $display("FAIL flush_two_vr: got v=%b rdy=%b exp v=0 rdy=1", o_Valid, o_Ready); end
        checks++; if (o_Instr !== 32'h0000_0013 || o_PC !== 32'h20) begin errors++; $display("FAIL flush_two_payload: got instr=%h pc=%h exp instr=00000013 pc=00000020", o_Instr, o_PC); end
        step();
        checks++; if (o_Valid !== 1'b0 || o_PC === 32'h18) begin errors++; $display("FAIL flush_two_after: got v=%b pc=%h exp v=0 pc!=00000018", o_Valid, o_PC); end
        // Flush in ONE with a same-cycle accept: accept must be dropped.
        drive(1'b1, 32'h30); step();
        drive(1'b1, 32'h34);
        i_Flush = 1'b1;
        step();
        i_Flush = 1'b0;
        drive(1'b0, 32'h0);
        checks++; if (o_Valid !== 1'b0 || o_PC !== 32'h30 || o_Instr !== 32'h0000_0013) begin errors++; $display("FAIL flush_one: got v=%b pc=%h instr=%h exp v=0 pc=00000030 instr=00000013", o_Valid, o_PC, o_Instr); end
        step();
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL flush_one_after: got %b exp 0", o_Valid); end
    endtask

    task automatic test_async_reset();
        i_Ready = 1'b0;
        drive(1'b1, 32'h40);
        step();
        drive(1'b0, 32'h0);
        checks++; if (o_Valid !== 1'b1 || o_PC !== 32'h40) begin errors++; $display("FAIL arst_pre: got v=%b pc=%h exp v=1 pc=00000040", o_Valid, o_PC); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (o_Valid !== 1'b0 || o_Ready !== 1'b1) begin errors++; $display("FAIL arst_vr: got v=%b rdy=%b exp v=0 rdy=1", o_Valid, o_Ready); end
        checks++; if (o_PC !== 32'h0 || o_PCPlus4 !== 32'h4 || o_Instr !== 32'h0000_0013) begin errors++; $display("FAIL arst_payload: got pc=%h pc4=%h instr=%h exp 00000000 00000004 00000013", o_PC, o_PCPlus4, o_Instr); end
        #1;
        rstn = 1'b1;
        step();
    endtask

`ifdef IF_DE_SKID_REG_PERF_EN
    task automatic test_perf();
        checks++; if (o_StallCnt !== 32'd0 || o_FlushCnt !== 32'd0) begin errors++; $display("FAIL perf_reset: got stall=%0d flush=%0d exp 0 0", o_StallCnt, o_FlushCnt); end
        i_Ready = 1'b0;
        drive(1'b1, 32'h50);
        step();
        drive(1'b0, 32'h0);
        repeat (5) step();
        i_Ready = 1'b1;
        i_Flush = 1'b1;
        repeat (2) step();
        i_Flush = 1'b0;
        step();
        checks++; if (o_StallCnt !== 32'd5) begin errors++; $display("FAIL perf_stall: got %0d exp 5", o_StallCnt); end
        checks++; if (o_FlushCnt !== 32'd2) begin errors++; $display("FAIL perf_flush: got %0d exp 2", o_FlushCnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef IF_DE_SKID_REG_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_if_de_skid_reg

// File: doc/if_de_skid_reg.md
Name: if_de_skid_reg

Overview:
- Next-generation IF->DE pipeline register with a valid/ready handshake on both sides and a 2-entry skid buffer.
- Decouples fetch from decode stalls while keeping in_ready fully registered, so no combinational ready path runs from DE back to IF.
- Carries PC, PC+4 and the instruction word, plus a valid bit.
- Supports synchronous flush for branch/jump redirect and parametrised XLEN and reset PC.

Parameters:
XLEN, 32, width of PC and PC+4 fields
ILEN, 32, instruction word width
RST_PC, 32'h0000_0000, reset value of the output PC; PC+4 resets to RST_PC+4
NOP_INSTR, 32'h0000_0013, instruction presented while empty or after reset (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
i_Flush  in  1  synchronous flush; discard all held entries
i_Valid  in  1  IF presents an entry
o_Ready  out  1  stage can accept; registered
i_PC  in  XLEN  fetched PC
i_PCPlus4  in  XLEN  fetched PC+4
i_Instr  in  ILEN  fetched instruction
o_Valid  out  1  entry presented to DE
i_Ready  in  1  DE accepts entry
o_PC  out  XLEN  PC of presented entry
o_PCPlus4  out  XLEN  PC+4 of presented entry
o_Instr  out  ILEN  instruction of presented entry

Behaviour:
- Reset (async, rstn=0): state EMPTY, o_Valid=0, o_Ready=1, o_PC=RST_PC, o_PCPlus4=RST_PC+4, o_Instr=NOP_INSTR, skid contents = the same values.
- Handshakes: accept = i_Valid & o_Ready; deliver = o_Valid & i_Ready. Both are evaluated on the same edge.
- Storage: a main register drives the outputs directly; a skid register holds one overflow entry.
- States:
  - EMPTY: o_Valid=0, o_Ready=1.
  - ONE: main holds an entry; o_Valid=1, o_Ready=1.
  - TWO: main and skid both full; o_Valid=1, o_Ready=0.
- Transitions (no flush):
  - EMPTY, accept -> ONE; main <= input.
  - ONE:
    - accept & deliver -> ONE; main <= input.
    - accept & !deliver -> TWO; skid <= input.
    - !accept & deliver -> EMPTY.
    - neither -> hold.
  - TWO:
    - deliver -> ONE; main <= skid.
    - otherwise hold. No accept is possible in TWO.
- Latency: 1 cycle from accept to o_Valid when empty or draining. Throughput is 1 entry/cycle while i_Ready=1.
- o_Ready is a flop: 1 in EMPTY/ONE, 0 in TWO. It is set for the next cycle from the next state.
- Payload registers load only on the accept/shift events listed above; otherwise they hold, with no toggling.
- Flush:
  - Has priority over all events.
  - Next state is EMPTY and o_Ready=1 next cycle.
  - Any same-cycle accept is dropped, and any same-cycle deliver still counts for DE.
  - Payload registers load NOP_INSTR into o_Instr. o_PC/o_PCPlus4 hold their last value.
- Boundaries:
  - i_Valid=0 in TWO is legal.
  - Upstream must hold i_Valid/payload until accepted; no stability check is done.
  - Reset asserted mid-transfer immediately returns to the reset values.
  - PC+4 is carried, not recomputed. Wrap at 2^XLEN is the upstream's concern.

Optional Feature:
- Macro: IF_DE_SKID_REG_PERF_EN.
- When defined, adds outputs o_StallCnt (32b) and o_FlushCnt (32b).
  - o_StallCnt increments each cycle o_Valid & !i_Ready.
  - o_FlushCnt increments each cycle i_Flush=1.
  - Both counters saturate at all-ones, reset to 0 asynchronously, and are not cleared by flush.
- When undefined, no counters and no extra ports. Core behaviour is identical either way.

Decomposition:
- Shared package (rv32i_pkg): XLEN, ILEN, NOP_INSTR, RST_PC default, and the state encoding enum (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
- One natural sub-module: pipe_payload_reg, a width-parametrised enable-load register with async reset value. It is instantiated for main and skid.
- Perf counters stay inline under the macro.

Test Plan:
- Reset release: after rstn rises, check o_Valid=0, o_Ready=1, o_PC=0x0, o_PCPlus4=0x4, o_Instr=0x00000013.
- Streaming: i_Ready=1, push PC 0x0,0x4,0x8 back-to-back -> o_PC shows 0x0,0x4,0x8 on consecutive cycles, 1-cycle latency, o_Ready stays 1.
- Backpressure: push 0x10, 0x14 with i_Ready=0 -> state TWO, o_Ready=0, o_PC=0x10. Raise i_Ready -> 0x10 then 0x14 delivered, no loss or duplication.
- Flush in TWO with simultaneous i_Valid (PC 0x18) -> next cycle o_Valid=0, o_Instr=0x00000013, o_Ready=1; 0x18 never appears.
- Async reset mid-stream in ONE (rstn pulsed low between edges) -> outputs go to reset values immediately, without waiting for clk.
- With IF_DE_SKID_REG_PERF_EN: hold i_Ready=0 for 5 cycles with an entry valid, then 2 flushes -> o_StallCnt=5, o_FlushCnt=2.
